// File: rtl/instr_receive_if.sv
// Receiver-side bundle: transmitter handshake (syn/ack/instr) and fetch-side
// show-ahead FIFO port (instr/valid/rd_en/count/done).
interface instr_receive_if #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned FDEPTH = 8
);
  localparam int unsigned CW = $clog2(FDEPTH) + 1;

  logic              r_i_en;
  logic              r_o_syn;
  logic [IWIDTH-1:0] r_i_instr;
  logic              r_i_ack;
  logic [IWIDTH-1:0] r_o_instr;
  logic              r_o_valid;
  logic              r_i_rd_en;
  logic [CW-1:0]     r_o_count;
  logic              r_o_done;

  modport slave (
    input  r_i_en, r_i_instr, r_i_ack, r_i_rd_en,
    output r_o_syn, r_o_instr, r_o_valid, r_o_count, r_o_done
  );

  modport master (
    output r_i_en, r_i_instr, r_i_ack, r_i_rd_en,
    input  r_o_syn, r_o_instr, r_o_valid, r_o_count, r_o_done
  );
endinterface

// File: rtl/instr_receive.sv
// Instruction receiver: level syn/ack fetch from the transmitter into a show-ahead FIFO.
// Optional stop-marker detection is enabled by defining RX_STOP_DETECT_EN.
module instr_receive #(
  parameter int unsigned       IWIDTH    = 32,
  parameter int unsigned       FDEPTH    = 8,
  parameter logic [IWIDTH-1:0] STOP_WORD = IWIDTH'(32'hFFFF_FFFF)
) (
  input logic            r_clk,
  input logic            r_rst,
  instr_receive_if.slave bus
);
  localparam int unsigned AW = $clog2(FDEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e            state_q;
  logic              syn_q;
  logic [IWIDTH-1:0] mem_q [FDEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [CW-1:0]     count_next;
  logic              valid;
  logic              pop;
  logic              capture;
  logic              stop_hit;
  logic              wr_en;
  logic              done;

  assign valid      = (count_q != '0);
  assign pop        = bus.r_i_rd_en && valid;
  assign capture    = (state_q == REQ) && bus.r_i_ack;
  assign wr_en      = capture && !stop_hit;
  assign count_next = count_q - CW'(pop);
  assign count_d    = count_next + CW'(wr_en);

`ifdef RX_STOP_DETECT_EN
  logic done_q;

  assign stop_hit = capture && (bus.r_i_instr == STOP_WORD);
  assign done     = done_q;

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      done_q <= 1'b0;
    end else if (stop_hit) begin
      done_q <= 1'b1;
    end
  end
`else
  logic unused_stop_word;

  assign stop_hit         = 1'b0;
  assign done             = 1'b0;
  assign unused_stop_word = ^STOP_WORD;
`endif

  // Room is judged on the post-pop count so a same-cycle pop can re-arm a full FIFO.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q <= IDLE;
      syn_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.r_i_en && !done && (count_next < CW'(FDEPTH))) begin
            state_q <= REQ;
            syn_q   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.r_i_ack) begin
            state_q <= GAP;
            syn_q   <= 1'b0;
          end
        end
        GAP: begin
          state_q <= IDLE;
          syn_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          syn_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge r_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.r_i_instr;
    end
  end

  assign bus.r_o_syn   = syn_q;
  assign bus.r_o_valid = valid;
  assign bus.r_o_count = count_q;
  assign bus.r_o_done  = done;
  assign bus.r_o_instr = valid ? mem_q[rd_ptr_q] : '0;

  // Only one word is ever outstanding, so a capture always finds room.
  a_no_overflow: assert property (@(posedge r_clk) disable iff (!r_rst)
    wr_en |-> (count_next < CW'(FDEPTH)));

  a_syn_in_req: assert property (@(posedge r_clk) disable iff (!r_rst)
    syn_q == (state_q == REQ));
endmodule
